// File: rtl/median_pkg.sv
// median_pkg: shared width default, clog2 helper and window type for the median pipeline
package median_pkg;
  localparam int DEFAULT_WIDTH = 32;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] word0;
    logic [DEFAULT_WIDTH-1:0] word1;
    logic [DEFAULT_WIDTH-1:0] word2;
  } window_t;
endpackage

// File: rtl/median_line_ram.sv
// median_line_ram: one-row pixel buffer, single port, combinational read returns pre-write data
module median_line_ram
  import median_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 64,
  parameter int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/median_column_buffer.sv
// median_column_buffer: 3-row column window feeder; MEDIAN_BORDER_REPLICATE_EN adds top-border row replication
module median_column_buffer
  import median_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IMG_WIDTH = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word0,
  output logic [WIDTH-1:0] out_word1,
  output logic [WIDTH-1:0] out_word2,
  output logic             frame_done
);
  localparam int XW = clog2(IMG_WIDTH);
  localparam int YW = clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] x_last = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] y_last = YW'(IMG_HEIGHT - 1);
  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic accept, row_end, emit;
  logic [WIDTH-1:0] r1, r2, w0, w1;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  // start-of-frame overrides the counters for the pixel it accompanies
  assign cx = in_sof ? '0 : x;
  assign cy = in_sof ? '0 : y;
  assign row_end = cx == x_last;
  median_line_ram #(.WIDTH(WIDTH), .DEPTH(IMG_WIDTH), .AW(XW)) u_line0 (
    .clk(clk), .we(accept), .addr(cx), .wdata(in_data), .rdata(r1)
  );
  median_line_ram #(.WIDTH(WIDTH), .DEPTH(IMG_WIDTH), .AW(XW)) u_line1 (
    .clk(clk), .we(accept), .addr(cx), .wdata(r1), .rdata(r2)
  );
`ifdef MEDIAN_BORDER_REPLICATE_EN
  assign emit = 1'b1;
  always_comb begin
    w0 = cy == '0 ? in_data : cy == YW'(1) ? r1 : r2;
    w1 = cy == '0 ? in_data : r1;
  end
`else
  assign emit = cy >= YW'(2);
  assign w0 = r2;
  assign w1 = r1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word0 <= '0;
      out_word1 <= '0;
      out_word2 <= '0;
      frame_done <= 1'b0;
      x <= '0;
      y <= '0;
    end else begin
      frame_done <= accept && row_end && cy == y_last;
      if (accept) begin
        x <= row_end ? '0 : cx + XW'(1);
        y <= !row_end ? cy : cy == y_last ? '0 : cy + YW'(1);
      end
      if (accept && emit) begin
        out_valid <= 1'b1;
        out_word0 <= w0;
        out_word1 <= w1;
        out_word2 <= in_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_median_column_buffer.sv
// tb_median_column_buffer: directed and randomized-handshake checks on a 4x4 image, pixel = 256*frame + 16*y + x
module tb_median_column_buffer;
  import median_pkg::*;
  localparam int W = 4;
  localparam int H = 4;
`ifdef MEDIAN_BORDER_REPLICATE_EN
  localparam int n_win = 16;
`else
  localparam int n_win = 8;
`endif
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sof, out_valid, out_ready, frame_done;
  logic [31:0] in_data, out_word0, out_word1, out_word2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  median_column_buffer #(.WIDTH(32), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_word0(out_word0), .out_word1(out_word1), .out_word2(out_word2), .frame_done(frame_done)
  );

  function automatic logic [31:0] pix(input int f, input int x, input int y);
    return 32'(256 * f + 16 * y + x);
  endfunction

  // rows above the top border take the nearest existing row
  function automatic window_t exp_win(input int f, input int x, input int y);
    window_t w;
    w.word2 = pix(f, x, y);
    w.word1 = y >= 1 ? pix(f, x, y - 1) : w.word2;
    w.word0 = y >= 2 ? pix(f, x, y - 2) : w.word1;
    return w;
  endfunction

  function automatic bit emits(input int y);
`ifdef MEDIAN_BORDER_REPLICATE_EN
    return y >= 0;
`else
    return y >= 2;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input int f, input int x, input int y);
    in_valid = 1'b1;
    in_sof = 1'b0;
    in_data = pix(f, x, y);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, frame_done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00", {out_valid, frame_done});
    end
    checks++;
    if ({out_word0, out_word1, out_word2} !== 96'h0) begin
      errors++;
      $display("FAIL reset_words got=%h exp=0", {out_word0, out_word1, out_word2});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_frame(input string tag);
    int wins = 0;
    int fds = 0;
    logic [97:0] got, exp;
    out_ready = 1'b1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        send(0, x, y);
        wins += int'(out_valid);
        fds += int'(frame_done);
        got = {out_valid, frame_done, out_valid ? {out_word0, out_word1, out_word2} : 96'h0};
        exp = {emits(y), x == W - 1 && y == H - 1, emits(y) ? exp_win(0, x, y) : 96'h0};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s_px(%0d,%0d) got=%h exp=%h", tag, x, y, got, exp);
        end
      end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, frame_done} !== 2'b00) begin
      errors++;
      $display("FAIL %s_drain got=%b exp=00", tag, {out_valid, frame_done});
    end
    checks++;
    if (wins != n_win || fds != 1) begin
      errors++;
      $display("FAIL %s_counts got windows=%0d done=%0d exp windows=%0d done=1", tag, wins, fds, n_win);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 2 * W + 1; k++) send(0, k % W, k / W);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = pix(0, 1, 2);
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_word0, out_word1, out_word2} !== {2'b01, exp_win(0, 0, 2)}) begin
        errors++;
        $display("FAIL stall_hold got=%h exp=%h", {in_ready, out_valid, out_word0, out_word1, out_word2},
                 {2'b01, exp_win(0, 0, 2)});
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_word0, out_word1, out_word2} !== {1'b1, 96'h00000001_00000011_00000021}) begin
      errors++;
      $display("FAIL stall_release got=%h exp=1_00000001_00000011_00000021",
               {out_valid, out_word0, out_word1, out_word2});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got=%b exp=0", out_valid);
    end
  endtask

`ifndef MEDIAN_BORDER_REPLICATE_EN
  task automatic test_sof();
    do_reset();
    for (int k = 0; k < 2 * W + 2; k++) send(0, k % W, k / W);
    in_valid = 1'b1;
    in_data = 32'h99;
    in_sof = 1'b1;
    @(posedge clk);
    #1 in_sof = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sof_pixel got=%b exp=0", out_valid);
    end
    for (int k = 1; k < 2 * W; k++) begin
      send(0, k % W, k / W);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sof_quiet(%0d,%0d) got=%b exp=0", k % W, k / W, out_valid);
      end
    end
    send(0, 0, 2);
    checks++;
    if ({out_valid, out_word0, out_word1, out_word2} !== {1'b1, 96'h00000099_00000010_00000020}) begin
      errors++;
      $display("FAIL sof_row2_x0 got=%h exp=1_00000099_00000010_00000020",
               {out_valid, out_word0, out_word1, out_word2});
    end
    send(0, 1, 2);
    checks++;
    if ({out_valid, out_word0, out_word1, out_word2} !== {1'b1, 96'h00000001_00000011_00000021}) begin
      errors++;
      $display("FAIL sof_row2_x1 got=%h exp=1_00000001_00000011_00000021",
               {out_valid, out_word0, out_word1, out_word2});
    end
    in_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3 * W + 2; k++) send(0, k % W, k / W);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got=%b exp=1", out_valid);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = pix(0, 2, 3);
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_word0, out_word1, out_word2} !== 97'h0) begin
      errors++;
      $display("FAIL rstmid_clear got=%h exp=0", {out_valid, out_word0, out_word1, out_word2});
    end
    rst = 1'b0;
    in_valid = 1'b0;
    test_full_frame("after_rst");
  endtask

`ifdef MEDIAN_BORDER_REPLICATE_EN
  task automatic test_replicate();
    do_reset();
    for (int k = 0; k < W * H; k++) begin
      send(0, k % W, k / W);
      if (k == 0) begin
        checks++;
        if ({out_valid, out_word0, out_word1, out_word2} !== {1'b1, 96'h0}) begin
          errors++;
          $display("FAIL repl_0_0 got=%h exp=1_0", {out_valid, out_word0, out_word1, out_word2});
        end
      end
      if (k == W + 2) begin
        checks++;
        if ({out_valid, out_word0, out_word1, out_word2} !== {1'b1, 96'h00000002_00000002_00000012}) begin
          errors++;
          $display("FAIL repl_2_1 got=%h exp=1_00000002_00000002_00000012",
                   {out_valid, out_word0, out_word1, out_word2});
        end
      end
    end
    in_valid = 1'b0;
  endtask
`endif

  task automatic test_random();
    window_t q[$];
    window_t w;
    int k = 0;
    int got = 0;
    int cyc = 0;
    int f, x, y;
    localparam int total = 3 * W * H;
    do_reset();
    while ((k < total || q.size() > 0 || out_valid) && cyc < 3000) begin
      f = k / (W * H);
      y = (k % (W * H)) / W;
      x = k % W;
      in_valid = k < total && $urandom_range(0, 3) != 0;
      in_data = pix(f, x, y);
      in_sof = k % (W * H) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        got++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got=%h exp=none", {out_word0, out_word1, out_word2});
        end else begin
          w = q.pop_front();
          if ({out_word0, out_word1, out_word2} !== w) begin
            errors++;
            $display("FAIL rand_window got=%h exp=%h", {out_word0, out_word1, out_word2}, w);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (emits(y)) q.push_back(exp_win(f, x, y));
        k++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    checks++;
    if (k != total || q.size() != 0 || got != 3 * n_win) begin
      errors++;
      $display("FAIL rand_totals got sent=%0d pending=%0d windows=%0d exp sent=%0d pending=0 windows=%0d",
               k, q.size(), got, total, 3 * n_win);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame("frame");
    test_stall();
`ifndef MEDIAN_BORDER_REPLICATE_EN
    test_sof();
`endif
    test_reset_mid();
`ifdef MEDIAN_BORDER_REPLICATE_EN
    test_replicate();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
